// File: rtl/cyclic_pkg.sv
// Shared types and constants for the parametrised systematic cyclic block encoder.
package cyclic_pkg;

   typedef enum logic {
      MSG = 1'b0,
      PAR = 1'b1
   } cyc_state_e;

   localparam logic [4:0] CYC15_11_POLY = 5'h13;
   localparam logic [3:0] CYC7_4_POLY   = 4'hB;

   // A usable generator needs both the leading and the constant coefficient set.
   function automatic bit poly_ok(input logic [255:0] poly, input int deg);
      if (deg < 1 || deg > 255) return 1'b0;
      return poly[deg] && poly[0];
   endfunction

endpackage

// File: rtl/cyclic_rem_lfsr.sv
// Remainder register: divides the message stream by g(x), then shifts out the parity.
module cyclic_rem_lfsr
   import cyclic_pkg::*;
#(
   parameter int         R        = 4,
   parameter logic [R:0] GEN_POLY = CYC15_11_POLY
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic shift_in,
   input  logic shift_out,
   input  logic d,
   output logic rem_msb
);

   localparam logic [R-1:0] TAPS = GEN_POLY[R-1:0];

   logic [R-1:0] rem_q;
   logic [R-1:0] rem_d;
   logic         fb;

   always_comb begin
      fb    = d ^ rem_q[R-1];
      rem_d = rem_q;
      if (clr) begin
         rem_d = '0;
      end else if (shift_in) begin
         rem_d = (rem_q << 1) ^ (fb ? TAPS : '0);
      end else if (shift_out) begin
         rem_d = rem_q << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign rem_msb = rem_q[R-1];

endmodule

// File: rtl/cyclic_encoder_param.sv
// Bit-serial systematic (N,K) cyclic encoder: K message bits pass through, then N-K parity bits.
module cyclic_encoder_param
   import cyclic_pkg::*;
#(
   parameter int             N        = 15,
   parameter int             K        = 11,
   parameter logic [N-K:0]   GEN_POLY = CYC15_11_POLY
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_valid,
   input  logic in_data,
   output logic in_ready,
   output logic out_valid,
   output logic out_data,
   input  logic out_ready,
   output logic out_sof,
   output logic out_eof
);

   localparam int R     = N - K;
   localparam int CNT_W = $clog2(N);

   localparam logic [CNT_W-1:0] LAST_MSG = CNT_W'(K - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

   if (!(N >= 3 && N <= 255 && K >= 1 && K < N)) begin : g_bad_size
      $error("cyclic_encoder_param: illegal N/K combination");
   end
   if (!poly_ok(256'(GEN_POLY), R)) begin : g_bad_poly
      $error("cyclic_encoder_param: GEN_POLY needs bits N-K and 0 set");
   end

   cyc_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             out_data_q, out_data_d;
   logic             out_sof_q, out_sof_d;
   logic             out_eof_q, out_eof_d;

   logic out_slot_free;
   logic accept;
   logic par_load;
   logic frame_done;
   logic rem_msb;

   always_comb begin
      out_slot_free = !out_valid_q || out_ready;
      in_ready      = (state_q == MSG) && out_slot_free;
      accept        = in_valid && in_ready;
      par_load      = (state_q == PAR) && out_slot_free;
      frame_done    = par_load && (cnt_q == LAST_BIT);

      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sof_d   = out_sof_q;
      out_eof_d   = out_eof_q;

      // Any new bit refills the output register; otherwise a taken bit empties it.
      if (accept || par_load) begin
         out_valid_d = 1'b1;
         out_data_d  = accept ? in_data : rem_msb;
         out_sof_d   = (cnt_q == '0);
         out_eof_d   = (cnt_q == LAST_BIT);
         cnt_d       = cnt_q + CNT_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         MSG: begin
            if (accept && cnt_q == LAST_MSG) begin
               state_d = PAR;
            end
         end
         PAR: begin
            if (frame_done) begin
               cnt_d   = '0;
               state_d = MSG;
            end
         end
         default: state_d = MSG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= MSG;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
      end
   end

   cyclic_rem_lfsr #(
      .R        (R),
      .GEN_POLY (GEN_POLY)
   ) u_rem (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (frame_done),
      .shift_in  (accept),
      .shift_out (par_load && !frame_done),
      .d         (in_data),
      .rem_msb   (rem_msb)
   );

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_cyclic_encoder_param.sv
// Bench for the cyclic encoder: polynomial-division model plus directed (15,11) and (7,4) frames.
module tb_cyclic_encoder_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic iv[2], id[2], ordy[2];
   logic ir[2], ov[2], od[2], osof[2], oeof[2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit   q0[$];
   bit   q1[$];
   int   acc_cnt[2], xfer_cnt[2], pos[2], last_sof[2];
   bit   stall_prev[2], post_rst[2], stall_en[2];
   logic hold_d[2], hold_s[2], hold_e[2];
   bit   chk_period;
   logic [31:0] got_cw[2];

   cyclic_encoder_param #(.N(15), .K(11), .GEN_POLY(5'h13)) dut15 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
      .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
      .out_sof(osof[0]), .out_eof(oeof[0])
   );

   cyclic_encoder_param #(.N(7), .K(4), .GEN_POLY(4'hB)) dut74 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
      .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
      .out_sof(osof[1]), .out_eof(oeof[1])
   );

   function automatic int n_of(input int u);
      return (u == 0) ? 15 : 7;
   endfunction
   function automatic int k_of(input int u);
      return (u == 0) ? 11 : 4;
   endfunction
   function automatic logic [31:0] poly_of(input int u);
      return (u == 0) ? 32'h13 : 32'hB;
   endfunction

   // Codeword = m*x^r + (m*x^r mod g), by long division over GF(2).
   function automatic logic [31:0] encode(input int n, input int k,
                                          input logic [31:0] poly, input logic [31:0] msg);
      logic [31:0] r;
      int rr;
      rr = n - k;
      r  = msg << rr;
      for (int i = n - 1; i >= rr; i--) begin
         if (r[i]) r = r ^ (poly << (i - rr));
      end
      return (msg << rr) | r;
   endfunction

   function automatic void push_bit(input int u, input bit b);
      if (u == 0) q0.push_back(b);
      else        q1.push_back(b);
   endfunction
   function automatic int q_size(input int u);
      return (u == 0) ? q0.size() : q1.size();
   endfunction
   function automatic bit pop_bit(input int u);
      if (u == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   task automatic chk(input bit ok, input string name, input int act, input int req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Compare process: every cycle checks in_ready, stall stability and each transferred bit.
   bit exp_ir;
   bit exp_b;
   int loaded;
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (!reset_n) begin
            if (u == 0) q0.delete();
            else        q1.delete();
            acc_cnt[u]    = 0;
            xfer_cnt[u]   = 0;
            pos[u]        = 0;
            stall_prev[u] = 1'b0;
            post_rst[u]   = 1'b1;
            last_sof[u]   = -1;
         end else begin
            if (post_rst[u]) begin
               chk(ov[u] == 1'b0,   "rst_out_valid", int'(ov[u]),   0);
               chk(od[u] == 1'b0,   "rst_out_data",  int'(od[u]),   0);
               chk(osof[u] == 1'b0, "rst_out_sof",   int'(osof[u]), 0);
               chk(oeof[u] == 1'b0, "rst_out_eof",   int'(oeof[u]), 0);
               chk(ir[u] == 1'b1,   "rst_in_ready",  int'(ir[u]),   1);
               post_rst[u] = 1'b0;
            end
            // Message phase whenever a frame is partially accepted or all owed bits are loaded.
            loaded = xfer_cnt[u] + (ov[u] ? 1 : 0);
            exp_ir = ((acc_cnt[u] % k_of(u)) != 0 ||
                      loaded == (acc_cnt[u] / k_of(u)) * n_of(u)) && (!ov[u] || ordy[u]);
            chk(ir[u] == exp_ir, "in_ready", int'(ir[u]), int'(exp_ir));
            if (stall_prev[u]) begin
               chk(ov[u] == 1'b1,        "stall_valid", int'(ov[u]), 1);
               chk(od[u] == hold_d[u],   "stall_data",  int'(od[u]), int'(hold_d[u]));
               chk(osof[u] == hold_s[u], "stall_sof",   int'(osof[u]), int'(hold_s[u]));
               chk(oeof[u] == hold_e[u], "stall_eof",   int'(oeof[u]), int'(hold_e[u]));
            end
            if (ov[u] && ordy[u]) begin
               if (q_size(u) == 0) begin
                  chk(1'b0, "unexpected_out", int'(od[u]), -1);
               end else begin
                  exp_b = pop_bit(u);
                  chk(od[u] == exp_b, "out_data", int'(od[u]), int'(exp_b));
                  chk(osof[u] == (pos[u] == 0), "out_sof", int'(osof[u]), int'(pos[u] == 0));
                  chk(oeof[u] == (pos[u] == n_of(u) - 1), "out_eof", int'(oeof[u]),
                      int'(pos[u] == n_of(u) - 1));
                  got_cw[u] = {got_cw[u][30:0], od[u]};
                  if (pos[u] == 0 && chk_period && u == 0) begin
                     if (last_sof[u] >= 0)
                        chk(cyc - last_sof[u] == n_of(u), "sof_period", cyc - last_sof[u], n_of(u));
                     last_sof[u] = cyc;
                  end
                  pos[u] = (pos[u] + 1) % n_of(u);
               end
               xfer_cnt[u]++;
            end
            if (iv[u] && ir[u]) acc_cnt[u]++;
            stall_prev[u] = ov[u] && !ordy[u];
            hold_d[u]     = od[u];
            hold_s[u]     = osof[u];
            hold_e[u]     = oeof[u];
         end
      end
      cyc++;
   end

   initial begin
      ordy[0] = 1'b1;
      ordy[1] = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int u = 0; u < 2; u++)
            ordy[u] = stall_en[u] ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   task automatic send_frame(input int u, input logic [31:0] msg, input bit gaps);
      logic [31:0] cw;
      bit took;
      int guard;
      cw = encode(n_of(u), k_of(u), poly_of(u), msg);
      for (int i = n_of(u) - 1; i >= 0; i--) push_bit(u, cw[i]);
      for (int i = k_of(u) - 1; i >= 0; i--) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            iv[u] = 1'b0;
            id[u] = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         iv[u] = 1'b1;
         id[u] = msg[i];
         took  = 1'b0;
         guard = 0;
         while (!took && guard < 200) begin
            @(negedge clk);
            took = ir[u];
            @(posedge clk);
            #1;
            guard++;
         end
         if (!took) begin
            chk(1'b0, "accept_timeout", guard, 200);
            break;
         end
      end
      iv[u] = 1'b0;
   endtask

   task automatic wait_drain(input int u);
      int guard;
      guard = 0;
      while ((q_size(u) != 0 || ov[u]) && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 500) chk(1'b0, "drain_timeout", q_size(u), 0);
   endtask

   initial begin
      logic [31:0] m;
      reset_n    = 1'b0;
      iv[0] = 1'b0; iv[1] = 1'b0;
      id[0] = 1'b0; id[1] = 1'b0;
      stall_en[0] = 1'b0; stall_en[1] = 1'b0;
      chk_period = 1'b0;
      got_cw[0]  = '0;
      got_cw[1]  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      chk(encode(15, 11, 32'h13, 32'h001) == 32'h0013, "model_15_11_one",
          int'(encode(15, 11, 32'h13, 32'h001)), 32'h0013);
      chk(encode(15, 11, 32'h13, 32'h400) == 32'h4009, "model_15_11_msb",
          int'(encode(15, 11, 32'h13, 32'h400)), 32'h4009);
      chk(encode(7, 4, 32'hB, 32'h1) == 32'h0B, "model_7_4_one",
          int'(encode(7, 4, 32'hB, 32'h1)), 32'h0B);

      for (int pass = 0; pass < 2; pass++) begin
         stall_en[0] = (pass == 1);
         send_frame(0, 32'h001, pass == 1);
         wait_drain(0);
         chk(got_cw[0][14:0] == 15'h0013, "cw_one", int'(got_cw[0][14:0]), 15'h0013);
         send_frame(0, 32'h400, pass == 1);
         wait_drain(0);
         chk(got_cw[0][3:0] == 4'b1001, "par_msb", int'(got_cw[0][3:0]), 4'b1001);
         send_frame(0, 32'h7FF, pass == 1);
         wait_drain(0);
         chk(got_cw[0][3:0] == 4'hF, "par_ones", int'(got_cw[0][3:0]), 4'hF);
      end
      stall_en[0] = 1'b0;

      chk_period  = 1'b1;
      last_sof[0] = -1;
      send_frame(0, 32'h001, 1'b0);
      send_frame(0, 32'h2A5, 1'b0);
      send_frame(0, 32'h400, 1'b0);
      send_frame(0, 32'h7FF, 1'b0);
      send_frame(0, 32'h123, 1'b0);
      wait_drain(0);
      chk_period = 1'b0;

      send_frame(0, 32'h5A5, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      send_frame(0, 32'h001, 1'b0);
      wait_drain(0);
      chk(got_cw[0][14:0] == 15'h0013, "cw_after_rst", int'(got_cw[0][14:0]), 15'h0013);

      for (int v = 0; v < 16; v++) begin
         m = 32'(v);
         stall_en[1] = m[0];
         send_frame(1, m, m[1]);
         wait_drain(1);
         if (v == 1)  chk(got_cw[1][6:0] == 7'h0B, "cw74_one",  int'(got_cw[1][6:0]), 7'h0B);
         if (v == 15) chk(got_cw[1][6:0] == 7'h7F, "cw74_ones", int'(got_cw[1][6:0]), 7'h7F);
      end
      stall_en[1] = 1'b0;

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/cyclic_encoder_param.md
# cyclic_encoder_param

Parametrised systematic (N,K) cyclic block encoder with bit-serial valid/ready streaming on both sides. Each frame accepts K message bits, MSB (highest degree) first, and passes them through unchanged. It then appends the N-K parity bits, which are the remainder of m(x)·x^(N-K) mod g(x). It sits between the bit-serial source and the channel modulator, and is the generalised successor of the fixed (15,11) serial coder.

## Interface
- N, default 15: codeword length in bits; 3 ≤ N ≤ 255.
- K, default 11: message length in bits; 1 ≤ K < N.
- GEN_POLY, default 'h13: generator g(x), width N-K+1. Bit i is the coefficient of x^i. Bit N-K and bit 0 must be 1 (elaboration-time check).
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset. The clock is clk; reset is synchronous and active-low.
- in_valid  in  1  in_data is valid.
- in_data  in  1  message bit.
- in_ready  out  1  encoder accepts in_data this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  1  codeword bit.
- out_ready  in  1  downstream accepts out_data.
- out_sof  out  1  qualifies out_data as codeword bit 0.
- out_eof  out  1  qualifies out_data as codeword bit N-1.

## Operation
- Remainder register rem[R-1:0] with R = N-K.
- On each accepted message bit d:
  - fb = d ^ rem[R-1].
  - rem <= (rem << 1) ^ (fb ? GEN_POLY[R-1:0] : 0).
- Bit counter cnt runs 0..N-1. Width is $clog2(N).
- FSM states are MSG and PAR.
- MSG:
  - in_ready = out_slot_free, where out_slot_free = !out_valid || out_ready.
  - On in_valid && in_ready: load the output register with d, update rem, and increment cnt.
  - When cnt == K-1 and the bit is accepted, go to PAR.
- PAR:
  - in_ready = 0.
  - When out_slot_free: load the output register with rem[R-1], set rem <= rem << 1, and increment cnt.
  - When cnt == N-1 and the bit is loaded: cnt <= 0, rem <= 0, go to MSG.
  - The next frame's first message bit may be accepted in the following cycle.
- out_sof is registered alongside a bit loaded with cnt == 0. out_eof is registered alongside a bit loaded with cnt == N-1.
- No bubble between message and parity: if out_ready is held high, the first parity bit follows the last message bit directly.
- Back-pressure: while out_valid && !out_ready, out_data, out_sof and out_eof hold stable and rem does not change.
- When in_valid is low in MSG, no state changes. out_valid drops once the held bit is taken.

## Timing
- Output register, latency 1: a bit accepted or generated in cycle t appears on out_data in cycle t+1.
- Throughput is 1 bit/cycle. With continuous in_valid and out_ready, a frame takes exactly N cycles and there are no idle cycles between frames.
- in_ready is combinational from out_valid, out_ready and the state. There is no combinational path from in_valid.
- Reset (reset_n low at a clock edge) applies in any state, including mid-frame:
  - state = MSG, cnt = 0, rem = 0.
  - out_valid = 0, out_data = 0, out_sof = 0, out_eof = 0.
  - The partial frame is discarded.
- Reset values of outputs: in_ready = 1 in the first cycle after reset; out_valid = 0; out_data = 0; out_sof = 0; out_eof = 0.
- K == 1: MSG lasts one accepted bit. R == 1 (K = N-1): single parity bit, equal to the message parity.

## Structure
- Package cyclic_pkg holds:
  - Typedef cyc_state_e {MSG, PAR}.
  - Function poly_ok(poly, deg) for the elaboration-time GEN_POLY check.
  - Default constants CYC15_11_POLY = 'h13 and CYC7_4_POLY = 'hB.
- Sub-module cyclic_rem_lfsr, parameters R and GEN_POLY. Ports:
  - Inputs: clk, reset_n, clr, shift_in (message bit, with feedback enabled), shift_out (parity shift, feedback disabled), d.
  - Output: rem_msb.
- The top module holds the FSM, cnt, the handshake and the output register.

## Test plan
- (15,11), g = 'h13, message 00000000001 streamed with out_ready = 1 -> out_data 000000000010011. out_sof on the first bit, out_eof on the 15th.
- Message 10000000000 -> parity 1001. Message of all 1s -> parity 1111.
- Same frames with random in_valid gaps and random out_ready stalls -> bit-identical codewords, out_data stable during every stall, and no accept while in_ready = 0.
- Back-to-back frames with continuous handshake -> 15-cycle period, out_sof every 15 outputs, and rem cleared between frames.
- Reset_n pulsed mid-parity -> the next cycle shows out_valid = 0 and in_ready = 1. The following frame encodes correctly.
- (7,4), g = 'hB, all 16 messages -> every codeword matches the reference model m·x^3 + (m·x^3 mod g).
